// File: rtl/prince_nf_round_ctrl.sv
// Purpose: round/stage sequencer for the 3-share PRINCE core (load, 12 S-box layers, whitening).
// Latency: start sampled in IDLE -> LOAD next cycle -> 12*NSTAGE RUN cycles -> one FIN cycle (done).
// Backpressure: none; start is ignored while busy and is not queued.
module prince_nf_round_ctrl #(
  parameter int NSTAGE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       load_en,
  output logic       state_en,
  output logic [1:0] stage_sel,
  output logic [3:0] layer_idx,
  output logic       inv_sel,
  output logic [1:0] lin_mode,
  output logic [3:0] rc_idx,
  output logic       whiten_en
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [1:0] LAST_STAGE = 2'(NSTAGE - 1);
  localparam logic [3:0] LAST_LAYER = 4'd11;

  // Linear-layer mode encodings
  localparam logic [1:0] LIN_NONE = 2'd0;
  localparam logic [1:0] LIN_FWD  = 2'd1;
  localparam logic [1:0] LIN_MID  = 2'd2;
  localparam logic [1:0] LIN_INV  = 2'd3;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] stage_q;
  logic [3:0] layer_q;
  logic       last_stage;
  logic       last_layer;

  assign last_stage = (stage_q == LAST_STAGE);
  assign last_layer = (layer_q == LAST_LAYER);

  // State register; reset drops straight to IDLE so every decoded output clears at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one-cycle LOAD and FIN around the RUN sweep; start only matters in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: state_d = S_RUN;
      S_RUN:  if (last_stage && last_layer) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage/layer counters advance only in RUN and sit at zero otherwise, so LOAD enters RUN at 0/0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= 2'd0;
      layer_q <= 4'd0;
    end else if (state_q == S_RUN) begin
      if (last_stage) begin
        stage_q <= 2'd0;
        layer_q <= last_layer ? 4'd0 : layer_q + 4'd1;
      end else begin
        stage_q <= stage_q + 2'd1;
      end
    end else begin
      stage_q <= 2'd0;
      layer_q <= 4'd0;
    end
  end

  // Output decode from state and counters only; start never reaches an output combinationally
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    load_en   = 1'b0;
    state_en  = 1'b0;
    stage_sel = 2'd0;
    layer_idx = 4'd0;
    inv_sel   = 1'b0;
    lin_mode  = LIN_NONE;
    rc_idx    = 4'd0;
    whiten_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
      end
      S_LOAD: begin
        busy     = 1'b1;
        load_en  = 1'b1;
        state_en = 1'b1;
      end
      S_RUN: begin
        busy      = 1'b1;
        state_en  = 1'b1;
        stage_sel = stage_q;
        layer_idx = layer_q;
        inv_sel   = (layer_q >= 4'd6);
        // Linear layer and key/RC add happen only as the layer's last stage is registered
        if (last_stage) begin
          if (layer_q <= 4'd4) begin
            lin_mode = LIN_FWD;
            rc_idx   = layer_q + 4'd1;
          end else if (layer_q == 4'd5) begin
            lin_mode = LIN_MID;
          end else if (layer_q <= 4'd10) begin
            lin_mode = LIN_INV;
            rc_idx   = layer_q;
          end
        end
      end
      S_FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_en  = 1'b1;
        whiten_en = 1'b1;
        rc_idx    = 4'd11;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_prince_nf_round_ctrl.sv
// Purpose: directed bench for prince_nf_round_ctrl at NSTAGE=2/3/4 against a cycle-indexed timeline.
// Latency: expected outputs derived from cycles since start acceptance (LOAD at 1, FIN at 2+12*NSTAGE).
// Backpressure: start pulses during a run must leave the timeline unchanged.
module tb_prince_nf_round_ctrl;

  logic clk;
  logic rst_n;
  logic start2, start3, start4;
  // Packed observation: {busy,done,load_en,state_en,stage_sel[1:0],layer_idx[3:0],inv_sel,lin_mode[1:0],rc_idx[3:0],whiten_en}
  wire [17:0] o2, o3, o4;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int done_q[$];
  int dc_pre;
  int base;

  // Hand-written per-layer linear mode and round-constant index on a layer's last stage
  int lin_tab[12] = '{1, 1, 1, 1, 1, 2, 3, 3, 3, 3, 3, 0};
  int rc_tab[12]  = '{1, 2, 3, 4, 5, 0, 6, 7, 8, 9, 10, 0};

  prince_nf_round_ctrl #(.NSTAGE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .busy(o3[17]), .done(o3[16]), .load_en(o3[15]), .state_en(o3[14]),
    .stage_sel(o3[13:12]), .layer_idx(o3[11:8]), .inv_sel(o3[7]),
    .lin_mode(o3[6:5]), .rc_idx(o3[4:1]), .whiten_en(o3[0])
  );

  prince_nf_round_ctrl #(.NSTAGE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .busy(o2[17]), .done(o2[16]), .load_en(o2[15]), .state_en(o2[14]),
    .stage_sel(o2[13:12]), .layer_idx(o2[11:8]), .inv_sel(o2[7]),
    .lin_mode(o2[6:5]), .rc_idx(o2[4:1]), .whiten_en(o2[0])
  );

  prince_nf_round_ctrl #(.NSTAGE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .busy(o4[17]), .done(o4[16]), .load_en(o4[15]), .state_en(o4[14]),
    .stage_sel(o4[13:12]), .layer_idx(o4[11:8]), .inv_sel(o4[7]),
    .lin_mode(o4[6:5]), .rc_idx(o4[4:1]), .whiten_en(o4[0])
  );

  // Clock: 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter for timestamping done pulses
  always @(posedge clk) cyc <= cyc + 1;

  // done monitor for the NSTAGE=3 instance, sampled on the falling edge
  always @(negedge clk) begin
    if (o3[16] === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_q.push_back(cyc);
    end
  end

  // Watchdog so the bench always ends
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected packed outputs c cycles after start was seen in IDLE (c=0 is that IDLE cycle)
  function automatic logic [17:0] exp_out(input int c, input int ns);
    logic bsy, dn, ld, se, inv, wh;
    logic [1:0] stg, lin;
    logic [3:0] lay, rc;
    int r;
    bsy = 0; dn = 0; ld = 0; se = 0; inv = 0; wh = 0;
    stg = 0; lin = 0; lay = 0; rc = 0;
    if (c == 1) begin
      bsy = 1; ld = 1; se = 1;
    end else if (c >= 2 && c <= 1 + 12 * ns) begin
      r   = c - 2;
      bsy = 1; se = 1;
      stg = 2'(r % ns);
      lay = 4'(r / ns);
      inv = ((r / ns) >= 6);
      if ((r % ns) == ns - 1) begin
        lin = 2'(lin_tab[r / ns]);
        rc  = 4'(rc_tab[r / ns]);
      end
    end else if (c == 2 + 12 * ns) begin
      bsy = 1; dn = 1; se = 1; wh = 1; rc = 4'd11;
    end
    return {bsy, dn, ld, se, stg, lay, inv, lin, rc, wh};
  endfunction

  initial begin
    rst_n  = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    start4 = 1'b0;

    // Reset state
    #3;
    check("rst n3", 32'(o3), 32'h0);
    step();
    step();
    check("rst n2", 32'(o2), 32'h0);
    check("rst n4", 32'(o4), 32'h0);
    rst_n = 1'b1;
    step();
    check("idle n3", 32'(o3), 32'h0);
    step();

    // Single run with ignored start pulses at 5/20/38, new accept at 39; NSTAGE=2/4 run alongside
    for (int c = 0; c <= 56; c++) begin
      start3 = (c == 0 || c == 5 || c == 20 || c == 38 || c == 39);
      start2 = (c == 0);
      start4 = (c == 0);
      check($sformatf("n3 c=%0d", c), 32'(o3), 32'((c >= 39) ? exp_out(c - 39, 3) : exp_out(c, 3)));
      check($sformatf("n2 c=%0d", c), 32'(o2), 32'(exp_out(c, 2)));
      check($sformatf("n4 c=%0d", c), 32'(o4), 32'(exp_out(c, 4)));
      if (c < 56) step();
    end
    check("done count first run", 32'(done_cnt), 32'd1);

    // Abort in cycle 17 of the second run (layer 5): outputs clear within the same cycle
    dc_pre = done_cnt;
    start3 = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("abort n3 async", 32'(o3), 32'h0);
    check("abort n2 async", 32'(o2), 32'h0);
    check("abort n4 async", 32'(o4), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("abort no done", 32'(done_cnt), 32'(dc_pre));
    check("after abort idle", 32'(o3), 32'h0);

    // Restart after reset behaves exactly like power-up
    for (int c = 0; c <= 39; c++) begin
      start3 = (c == 0);
      check($sformatf("restart c=%0d", c), 32'(o3), 32'(exp_out(c, 3)));
      step();
    end
    check("restart done count", 32'(done_cnt), 32'(dc_pre + 1));

    // start held high for 200 cycles: back-to-back runs every 39 cycles
    done_q.delete();
    base   = cyc;
    start3 = 1'b1;
    for (int c = 0; c < 200; c++) begin
      check($sformatf("held c=%0d", c), 32'(o3), 32'(exp_out(c % 39, 3)));
      step();
    end
    start3 = 1'b0;
    check("held done pulses", 32'(done_q.size()), 32'd5);
    for (int k = 0; k < done_q.size() && k < 5; k++) begin
      check($sformatf("held done %0d cycle", k), 32'(done_q[k] - base), 32'(38 + 39 * k));
      if (k > 0) check($sformatf("held gap %0d", k), 32'(done_q[k] - done_q[k-1]), 32'd39);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
